// File: rtl/pipe_pkg.sv
// Shared constants, types and helpers for the pipe scheduler slice.
// Imported by the LFSR and by the top-level game-flow controller.
package pipe_pkg;

  localparam int          NUM_PIPES  = 4;
  localparam logic [12:0] INIT_X     = 13'd640;
  localparam logic [12:0] HALF_WIDTH = 13'd24;
  localparam logic [12:0] GAP_HALF   = 13'd50;
  localparam logic [12:0] GAP_BASE   = 13'd112;
  localparam logic [12:0] INIT_GAP   = 13'd240;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  typedef logic [NUM_PIPES-1:0][12:0] pipeVec_t;

  // Starting X positions: pipes lined up off the right edge, SPACING apart.
  function automatic pipeVec_t initPipes(input int spacing);
    pipeVec_t r;
    for (int i = 0; i < NUM_PIPES; i++) begin
      r[i] = INIT_X + 13'(i * spacing);
    end
    return r;
  endfunction

  // Two-digit BCD increment that saturates at 99.
  function automatic logic [7:0] bcdInc(input logic [7:0] s);
    if (s == 8'h99) return s;
    if (s[3:0] == 4'd9) return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/pipe_scheduler_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 15,13,12,10) free-running every clock.
// Supplies pseudo-random gap locations for respawned pipes.
module lfsr16
  import pipe_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  output logic [15:0] q
);

  // NOTE: reset is synchronous, so it lives inside the clocked block and is
  // only seen on a rising Clk edge; sequential state always uses <=.
  always_ff @(posedge Clk) begin
    if (!Reset_n) q <= LFSR_SEED;
    else          q <= {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Game-flow controller: IDLE/RUN/DEAD state, pipe scrolling and respawn,
// bird-pass detection and a saturating two-digit BCD score.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int SPEED   = 2,
  parameter int SPACING = 200
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          frame_clk,
  input  logic                          start,
  input  logic                          hit,
  input  logic [9:0]                    BirdX,
  output logic [NUM_PIPES-1:0][12:0]    pipeX,
  output logic [NUM_PIPES-1:0][12:0]    pipeWidth,
  output logic [NUM_PIPES-1:0][12:0]    pipeGapSize,
  output logic [NUM_PIPES-1:0][12:0]    pipeGapLocation,
  output logic [7:0]                    score,
  output logic                          running
);

  localparam logic [12:0] SPEED13       = 13'(SPEED);
  localparam logic [12:0] RESPAWN_LIMIT = HALF_WIDTH + SPEED13;
  localparam logic [12:0] WRAP_STEP     = 13'(NUM_PIPES * SPACING - SPEED);
  localparam pipeVec_t    INIT_PIPES    = initPipes(SPACING);

  state_t                 state;
  logic                   fQ, sQ;
  logic                   tick, startEv;
  logic [15:0]            lfsr;
  logic [12:0]            birdX13;
  pipeVec_t               nextX, nextGap;
  logic [NUM_PIPES-1:0]   respawn, passed;
  logic                   anyPass;
  logic                   unusedLfsrBits;

  lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .q       (lfsr)
  );

  assign tick           = frame_clk & ~fQ;
  assign startEv        = start & ~sQ;
  assign birdX13        = {3'd0, BirdX};
  assign unusedLfsrBits = ^lfsr[15:8];

  // The respawn guard keeps the subtraction from ever wrapping below zero.
  for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
    assign respawn[i] = pipeX[i] < RESPAWN_LIMIT;
    assign nextX[i]   = respawn[i] ? pipeX[i] + WRAP_STEP : pipeX[i] - SPEED13;
    assign nextGap[i] = respawn[i] ? GAP_BASE + {5'd0, lfsr[7:0]} : pipeGapLocation[i];
    assign passed[i]  = !respawn[i]
                        && (pipeX[i] + HALF_WIDTH >= birdX13)
                        && (nextX[i] + HALF_WIDTH < birdX13);
  end

  assign anyPass     = |passed;
  assign pipeWidth   = {NUM_PIPES{HALF_WIDTH}};
  assign pipeGapSize = {NUM_PIPES{GAP_HALF}};
  assign running     = (state == RUN);

  always_ff @(posedge Clk) begin
    // Edge detectors keep sampling through reset, so a level held across
    // reset release does not masquerade as a fresh event.
    fQ <= frame_clk;
    sQ <= start;
    if (!Reset_n) begin
      state           <= IDLE;
      pipeX           <= INIT_PIPES;
      pipeGapLocation <= {NUM_PIPES{INIT_GAP}};
      score           <= 8'h00;
    end else begin
      case (state)
        IDLE: if (startEv) state <= RUN;
        RUN: begin
          if (hit) begin
            state <= DEAD;
          end else if (tick) begin
            pipeX           <= nextX;
            pipeGapLocation <= nextGap;
            if (anyPass) score <= bcdInc(score);
          end
        end
        DEAD: begin
          if (startEv) begin
            state           <= RUN;
            pipeX           <= INIT_PIPES;
            pipeGapLocation <= {NUM_PIPES{INIT_GAP}};
            score           <= 8'h00;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_scheduler.sv
// Directed self-checking bench for pipe_scheduler (SPEED=2, SPACING=200).
// Expected positions and scores are hand-computed; gap values use a reference LFSR.
module tb_pipe_scheduler;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              frame_clk;
  logic              start;
  logic              hit;
  logic [9:0]        BirdX;
  logic [3:0][12:0]  pipeX;
  logic [3:0][12:0]  pipeWidth;
  logic [3:0][12:0]  pipeGapSize;
  logic [3:0][12:0]  pipeGapLocation;
  logic [7:0]        score;
  logic              running;

  int          errors = 0;
  int          checks = 0;
  int          tickCount = 0;
  logic [15:0] refLfsr;
  logic [15:0] lfsrAtTick;

  pipe_scheduler #(.SPEED(2), .SPACING(200)) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .frame_clk       (frame_clk),
    .start           (start),
    .hit             (hit),
    .BirdX           (BirdX),
    .pipeX           (pipeX),
    .pipeWidth       (pipeWidth),
    .pipeGapSize     (pipeGapSize),
    .pipeGapLocation (pipeGapLocation),
    .score           (score),
    .running         (running)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: seed and taps straight from the description.
  always_ff @(posedge Clk) begin
    if (!Reset_n) refLfsr <= 16'hACE1;
    else          refLfsr <= {refLfsr[14:0], refLfsr[15] ^ refLfsr[13] ^ refLfsr[12] ^ refLfsr[10]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One frame_clk pulse; outputs are settled at the returning negedge.
  task automatic doTick();
    @(negedge Clk);
    frame_clk  = 1'b1;
    lfsrAtTick = refLfsr;
    @(negedge Clk);
    frame_clk  = 1'b0;
    tickCount++;
  endtask

  task automatic ticksTo(input int n);
    while (tickCount < n) doTick();
  endtask

  task automatic pulseStart();
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
  endtask

  task automatic checkInit(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_x%0d", tag, i), pipeX[i], 640 + 200 * i);
      check($sformatf("%s_gap%0d", tag, i), pipeGapLocation[i], 240);
    end
    check({tag, "_score"}, score, 8'h00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    start     = 1'b0;
    hit       = 1'b0;
    BirdX     = 10'd200;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;

    checkInit("reset");
    check("reset_running", running, 1'b0);
    check("width0", pipeWidth[0], 24);
    check("gapsize3", pipeGapSize[3], 50);

    // Ticks and hit in IDLE change nothing.
    for (int i = 0; i < 10; i++) doTick();
    @(negedge Clk);
    hit = 1'b1;
    @(negedge Clk);
    hit = 1'b0;
    checkInit("idle");
    check("idle_running", running, 1'b0);

    pulseStart();
    check("start_running", running, 1'b1);
    tickCount = 0;
    for (int i = 0; i < 10; i++) doTick();
    check("run10_x0", pipeX[0], 620);
    check("run10_x3", pipeX[3], 1220);
    check("run10_score", score, 8'h00);

    // frame_clk held high for several clocks gives a single update.
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (3) @(negedge Clk);
    frame_clk = 1'b0;
    @(negedge Clk);
    tickCount++;
    check("held_frame_x0", pipeX[0], 618);

    pulseStart();
    check("start_in_run_running", running, 1'b1);
    check("start_in_run_x0", pipeX[0], 618);

    // Pipe 0 right edge crosses BirdX=200 when X goes 176 -> 174.
    ticksTo(232);
    check("prepass_x0", pipeX[0], 176);
    check("prepass_score", score, 8'h00);
    doTick();
    check("pass_x0", pipeX[0], 174);
    check("pass_score", score, 8'h01);
    doTick();
    check("pass_once_score", score, 8'h01);

    // Boundary: 26 still scrolls to 24, then 24 respawns to 822.
    ticksTo(308);
    check("edge_x0", pipeX[0], 24);
    check("edge_gap0", pipeGapLocation[0], 240);
    doTick();
    check("respawn_x0", pipeX[0], 822);
    check("respawn_gap0", pipeGapLocation[0], 13'd112 + {5'd0, lfsrAtTick[7:0]});
    check("respawn_x1", pipeX[1], 222);
    check("respawn_score", score, 8'h01);

    // One pass every 100 ticks from tick 233 on.
    ticksTo(1032);
    check("score_08", score, 8'h08);
    ticksTo(1033);
    check("score_09", score, 8'h09);
    ticksTo(1133);
    check("score_10", score, 8'h10);
    ticksTo(10033);
    check("score_99", score, 8'h99);
    ticksTo(10133);
    check("score_sat", score, 8'h99);
    check("sat_x3", pipeX[3], 174);

    // hit and tick together: hit wins, no movement.
    @(negedge Clk);
    frame_clk = 1'b1;
    hit       = 1'b1;
    @(negedge Clk);
    frame_clk = 1'b0;
    check("hit_running", running, 1'b0);
    check("hit_x0", pipeX[0], 374);
    check("hit_x1", pipeX[1], 574);
    check("hit_x2", pipeX[2], 774);
    check("hit_x3", pipeX[3], 174);
    for (int i = 0; i < 3; i++) doTick();
    check("dead_x0", pipeX[0], 374);
    check("dead_score", score, 8'h99);
    check("dead_running", running, 1'b0);
    hit = 1'b0;

    pulseStart();
    check("restart_running", running, 1'b1);
    checkInit("restart");

    // Reset during RUN with start held: no start event until it re-rises.
    doTick();
    doTick();
    check("prereset_x0", pipeX[0], 636);
    @(negedge Clk);
    Reset_n = 1'b0;
    start   = 1'b1;
    @(negedge Clk);
    Reset_n = 1'b1;
    check("midrun_reset_running", running, 1'b0);
    checkInit("midrun_reset");
    repeat (3) @(negedge Clk);
    check("held_start_running", running, 1'b0);
    start = 1'b0;
    @(negedge Clk);
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    check("rearm_running", running, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
